// File: rtl/mic_frame_scheduler_if.sv
// Codec write port of the mic frame scheduler.
// One left/right sample pair moves per cycle with write high.
interface mic_frame_scheduler_if #(
    parameter int DATA_W = 16
);
    logic              write;
    logic              write_ready;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;

    modport master (
        output write,
        output writedata_left,
        output writedata_right,
        input  write_ready
    );

    modport slave (
        input  write,
        input  writedata_left,
        input  writedata_right,
        output write_ready
    );
endinterface

// File: rtl/mic_frame_scheduler.sv
// Collects one L/R sample per I2S mic, then forwards one mic or the
// mix of enabled mics to the codec as a single write per frame.
module mic_frame_scheduler #(
    parameter int NUM_MICS = 4,
    parameter int DATA_W   = 16,
    localparam int IW      = $clog2(NUM_MICS),
    localparam int AW      = DATA_W + IW
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [NUM_MICS-1:0]        sample_valid,
    input  logic [NUM_MICS*DATA_W-1:0] sample_left,
    input  logic [NUM_MICS*DATA_W-1:0] sample_right,
    input  logic                       mode_mix,
    input  logic [IW-1:0]              mic_sel,
    input  logic [NUM_MICS-1:0]        mic_en,
    mic_frame_scheduler_if.master      codec,
    output logic                       busy,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 overrun_cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, WRITE} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    hold_l [NUM_MICS];
    logic [DATA_W-1:0]    hold_r [NUM_MICS];
    logic [NUM_MICS-1:0]  pending, req_q, req_now, consume;
    logic                 mode_q;
    logic [IW-1:0]        idx;
    logic signed [AW-1:0] acc_l, acc_r, add_l, add_r;
    logic [DATA_W-1:0]    wd_l, wd_r;
    logic                 start, write_fire, overrun_hit;

    assign req_now = mode_mix ? mic_en : NUM_MICS'(1) << mic_sel;
    assign add_l   = {{IW{hold_l[idx][DATA_W-1]}}, hold_l[idx]};
    assign add_r   = {{IW{hold_r[idx][DATA_W-1]}}, hold_r[idx]};

    // A mic being consumed this cycle may reload without counting as overrun
    always_comb begin
        consume = '0;
        if (state_q == ACCUM && req_q[idx])
            consume[idx] = 1'b1;
    end

    assign overrun_hit = |(sample_valid & pending & ~consume);

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        write_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_now != '0 && (pending & req_now) == req_now) begin
                    start   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (idx == IW'(NUM_MICS - 1))
                    state_d = OUTPUT;
            end
            OUTPUT: state_d = WRITE;
            WRITE: begin
                if (codec.write_ready) begin
                    write_fire = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign codec.write           = write_fire;
    assign codec.writedata_left  = wd_l;
    assign codec.writedata_right = wd_r;
    assign busy                  = (state_q != IDLE);

    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NUM_MICS; i++) begin
            if (!reset_reset_n) begin
                hold_l[i] <= '0;
                hold_r[i] <= '0;
            end else if (sample_valid[i]) begin
                hold_l[i] <= sample_left[i*DATA_W +: DATA_W];
                hold_r[i] <= sample_right[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            pending     <= '0;
            req_q       <= '0;
            mode_q      <= 1'b0;
            idx         <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            wd_l        <= '0;
            wd_r        <= '0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            state_q <= state_d;
            pending <= (pending & ~consume) | sample_valid;
            if (overrun_hit && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (start) begin
                req_q  <= req_now;
                mode_q <= mode_mix;
                idx    <= '0;
                acc_l  <= '0;
                acc_r  <= '0;
            end
            if (state_q == ACCUM) begin
                idx <= idx + IW'(1);
                if (req_q[idx]) begin
                    acc_l <= acc_l + add_l;
                    acc_r <= acc_r + add_r;
                end
            end
            // Mix divides by NUM_MICS whatever the enabled count
            if (state_q == OUTPUT) begin
                wd_l <= mode_q ? DATA_W'(acc_l >>> IW) : acc_l[DATA_W-1:0];
                wd_r <= mode_q ? DATA_W'(acc_r >>> IW) : acc_r[DATA_W-1:0];
            end
            if (write_fire)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mic_frame_scheduler.sv
// Bench for mic_frame_scheduler: vector table, directed corner
// sequences and randomized frames against a frame-level model.
module tb_mic_frame_scheduler;
    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk_clk = 1'b0;
    logic            reset_reset_n = 1'b0;
    logic [N-1:0]    sample_valid = '0;
    logic [N*DW-1:0] sample_left = '0;
    logic [N*DW-1:0] sample_right = '0;
    logic            mode_mix = 1'b0;
    logic [1:0]      mic_sel = '0;
    logic [N-1:0]    mic_en = '0;
    logic            busy;
    logic [15:0]     frame_cnt;
    logic [7:0]      overrun_cnt;

    mic_frame_scheduler_if #(.DATA_W(DW)) codec ();

    mic_frame_scheduler #(.NUM_MICS(N), .DATA_W(DW)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sample_valid  (sample_valid),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .mode_mix      (mode_mix),
        .mic_sel       (mic_sel),
        .mic_en        (mic_en),
        .codec         (codec),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .overrun_cnt   (overrun_cnt)
    );

    always #10 clk_clk = ~clk_clk;

    int n_err = 0;
    int n_chk = 0;

    // Model: buffered sample and pending flag per mic, plus counters
    logic [DW-1:0] m_l [N];
    logic [DW-1:0] m_r [N];
    bit            m_pend [N];
    int            m_frames = 0;
    int            m_ovr = 0;

    typedef struct {
        bit            mix;
        int            sel;
        logic [N-1:0]  en;
        logic [N*DW-1:0] l;
        logic [N*DW-1:0] r;
        logic [DW-1:0] el;
        logic [DW-1:0] er;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] lane(int i, logic [DW-1:0] v);
        logic [N*DW-1:0] x;
        x = '0;
        x[i*DW +: DW] = v;
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_frames = 0;
        m_ovr    = 0;
    endtask

    // Drive one cycle of sample_valid; only used when no mic is being consumed
    task automatic deliver(input logic [N-1:0] mask,
                           input logic [N*DW-1:0] l,
                           input logic [N*DW-1:0] r);
        bit hit;
        hit = 1'b0;
        sample_valid = mask;
        sample_left  = l;
        sample_right = r;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (m_pend[i]) hit = 1'b1;
                m_l[i]    = l[i*DW +: DW];
                m_r[i]    = r[i*DW +: DW];
                m_pend[i] = 1'b1;
            end
        end
        if (hit && m_ovr < 255) m_ovr++;
        step();
        sample_valid = '0;
    endtask

    task automatic deliver1(input int i, input logic [DW-1:0] l,
                            input logic [DW-1:0] r);
        deliver(N'(1) << i, lane(i, l), lane(i, r));
    endtask

    // Sum of the signed samples, divided by N when mixing
    task automatic expect_frame(input bit mix, input logic [N-1:0] req,
                                output logic [DW-1:0] el,
                                output logic [DW-1:0] er);
        int sl, sr;
        sl = 0;
        sr = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                sl += int'($signed(m_l[i]));
                sr += int'($signed(m_r[i]));
                m_pend[i] = 1'b0;
            end
        end
        if (mix) begin
            sl = sl / N - ((sl % N != 0 && sl < 0) ? 1 : 0);
            sr = sr / N - ((sr % N != 0 && sr < 0) ? 1 : 0);
        end
        el = sl[DW-1:0];
        er = sr[DW-1:0];
        m_frames++;
    endtask

    task automatic wait_write(input string name, input logic [DW-1:0] el,
                              input logic [DW-1:0] er, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            codec.write_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (codec.write) begin
                seen = 1'b1;
                chk({name, "_left"}, 32'(codec.writedata_left), 32'(el));
                chk({name, "_right"}, 32'(codec.writedata_right), 32'(er));
            end
            step();
        end
        codec.write_ready = 1'b1;
        chk({name, "_write_seen"}, 32'(seen), 32'd1);
        chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frames[15:0]));
        chk({name, "_overrun_cnt"}, 32'(overrun_cnt), 32'(m_ovr));
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] el, er;
        logic [N-1:0]  req;
        int            bad, na, m, tmp;
        int            miss[$];

        tbl[0] = '{0, 0, 4'h0, lane(0, 16'h7FFF), lane(0, 16'h0001),
                   16'h7FFF, 16'h0001};
        tbl[1] = '{1, 0, 4'hF, {16'd400, 16'hFED4, 16'd200, 16'd100},
                   {4{16'd4}}, 16'd100, 16'd4};
        tbl[2] = '{1, 0, 4'hF, {4{16'h8000}}, {4{16'h7FFF}},
                   16'h8000, 16'h7FFF};
        tbl[3] = '{1, 0, 4'h3, {16'h1111, 16'h2222, 16'hF830, 16'h03E8},
                   {32'h0, 16'h0, 16'h0003}, 16'hFF06, 16'h0000};
        tbl[4] = '{0, 3, 4'h0, lane(3, 16'hABCD), lane(3, 16'h1357),
                   16'hABCD, 16'h1357};
        tbl[5] = '{1, 0, 4'h4, lane(2, 16'hFFFF), lane(2, 16'h0007),
                   16'hFFFF, 16'h0001};

        model_reset();
        codec.write_ready = 1'b1;
        repeat (3) step();
        chk("rst_write", 32'(codec.write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        chk("rst_wd", {codec.writedata_left, codec.writedata_right}, 32'd0);
        reset_reset_n = 1'b1;
        step();

        // Latency: valid in cycle t, write in cycle t+7
        mode_mix = 1'b0;
        mic_sel  = 2'd2;
        step();
        deliver1(2, 16'h1234, 16'hFEDC);
        bad = 0;
        for (int n = 1; n <= 6; n++) begin
            if (codec.write) bad++;
            step();
        end
        chk("lat_no_early_write", 32'(bad), 32'd0);
        chk("lat_write_t7", 32'(codec.write), 32'd1);
        chk("lat_left", 32'(codec.writedata_left), 32'h1234);
        chk("lat_right", 32'(codec.writedata_right), 32'hFEDC);
        expect_frame(1'b0, 4'b0100, el, er);
        step();
        chk("lat_frame_cnt", 32'(frame_cnt), 32'd1);
        bad = 0;
        repeat (10) begin
            if (busy || codec.write) bad++;
            step();
        end
        chk("lat_pending_cleared", 32'(bad), 32'd0);

        for (int v = 0; v < 6; v++) begin
            mode_mix = tbl[v].mix;
            mic_sel  = 2'(tbl[v].sel);
            mic_en   = tbl[v].en;
            req      = tbl[v].mix ? tbl[v].en : N'(1) << tbl[v].sel;
            step();
            deliver(req, tbl[v].l, tbl[v].r);
            expect_frame(tbl[v].mix, req, el, er);
            wait_write($sformatf("vec%0d", v), tbl[v].el, tbl[v].er, 1'b0);
        end

        // Mic 3 pending is left alone by a mic 0/1 mix, then drained
        mode_mix = 1'b1;
        mic_en   = 4'b0011;
        deliver1(3, 16'h0BAD, 16'h0001);
        repeat (4) step();
        chk("partial_wait_idle", 32'(busy), 32'd0);
        deliver(4'b0011, {32'h0, 16'h0080, 16'h0040}, '0);
        expect_frame(1'b1, 4'b0011, el, er);
        wait_write("partial_mix", el, er, 1'b0);
        mode_mix = 1'b0;
        mic_sel  = 2'd3;
        expect_frame(1'b0, 4'b1000, el, er);
        wait_write("partial_drain", el, er, 1'b0);

        // Empty mix mask never starts a frame
        mode_mix = 1'b1;
        mic_en   = '0;
        deliver(4'hF, {4{16'd8}}, {4{16'd16}});
        bad = 0;
        repeat (30) begin
            if (codec.write || busy) bad++;
            step();
        end
        chk("en0_no_write", 32'(bad), 32'd0);
        mic_en = 4'hF;
        expect_frame(1'b1, 4'hF, el, er);
        wait_write("en0_drain", el, er, 1'b0);

        // Overrun on a required mic: newest value wins
        mic_en = 4'b0011;
        deliver1(1, 16'h0100, 16'h0000);
        deliver1(1, 16'h0200, 16'h0000);
        deliver1(0, 16'h0400, 16'h0000);
        expect_frame(1'b1, 4'b0011, el, er);
        wait_write("overrun_one", el, er, 1'b0);
        chk("overrun_one_cnt", 32'(overrun_cnt), 32'd1);
        for (int k = 0; k <= 300; k++) deliver1(3, 16'(k), 16'(k + 7));
        chk("overrun_saturate", 32'(overrun_cnt), 32'd255);
        mode_mix = 1'b0;
        mic_sel  = 2'd3;
        expect_frame(1'b0, 4'b1000, el, er);
        wait_write("overrun_drain", el, er, 1'b0);

        // Codec back-pressure: write held off, data stable
        codec.write_ready = 1'b0;
        mic_sel = 2'd0;
        deliver1(0, 16'h5A5A, 16'hA5A5);
        expect_frame(1'b0, 4'b0001, el, er);
        repeat (10) step();
        bad = 0;
        repeat (50) begin
            if (codec.write || !busy) bad++;
            if (codec.writedata_left != el || codec.writedata_right != er) bad++;
            step();
        end
        chk("stall_hold", 32'(bad), 32'd0);
        codec.write_ready = 1'b1;
        #1;
        chk("stall_release_write", 32'(codec.write), 32'd1);
        step();
        chk("stall_single_pulse", 32'(codec.write), 32'd0);
        chk("stall_idle", 32'(busy), 32'd0);
        chk("stall_frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));

        // Reset in the middle of ACCUM
        mic_sel = 2'd1;
        deliver1(1, 16'h7777, 16'h8888);
        repeat (2) step();
        chk("mid_rst_in_frame", 32'(busy), 32'd1);
        reset_reset_n = 1'b0;
        step();
        model_reset();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_write", 32'(codec.write), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        chk("mid_rst_wd", {codec.writedata_left, codec.writedata_right}, 32'd0);
        reset_reset_n = 1'b1;
        bad = 0;
        repeat (10) begin
            if (codec.write || busy) bad++;
            step();
        end
        chk("mid_rst_no_write", 32'(bad), 32'd0);
        deliver1(1, 16'h0ACE, 16'h0DEF);
        expect_frame(1'b0, 4'b0010, el, er);
        wait_write("post_rst", el, er, 1'b0);

        // Randomized frames
        for (int t = 0; t < 40; t++) begin
            codec.write_ready = 1'b0;
            mode_mix = 1'($urandom_range(0, 1));
            mic_sel  = 2'($urandom_range(0, 3));
            mic_en   = 4'($urandom_range(1, 15));
            req      = mode_mix ? mic_en : N'(1) << mic_sel;
            na       = (req == '1) ? 0 : int'($urandom_range(0, 3));
            for (int k = 0; k < na; k++) begin
                do m = int'($urandom_range(0, 3)); while (req[m]);
                repeat ($urandom_range(0, 2)) step();
                deliver1(m, 16'($urandom), 16'($urandom));
            end
            miss.delete();
            for (int i = 0; i < N; i++)
                if (req[i] && !m_pend[i]) miss.push_back(i);
            for (int i = miss.size() - 1; i > 0; i--) begin
                m = int'($urandom_range(0, i));
                tmp = miss[i];
                miss[i] = miss[m];
                miss[m] = tmp;
            end
            for (int j = 0; j < miss.size(); j++) begin
                repeat ($urandom_range(0, 2)) step();
                if (j == miss.size() - 1 && j > 0 && $urandom_range(0, 1) == 1)
                    deliver1(miss[0], 16'($urandom), 16'($urandom));
                deliver1(miss[j], 16'($urandom), 16'($urandom));
            end
            expect_frame(mode_mix, req, el, er);
            wait_write($sformatf("rand%0d", t), el, er, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mic_frame_scheduler.md
# mic_frame_scheduler

Sequences per-frame audio from several I2S microphone receivers onto the single audio-codec write port. It buffers one left/right sample per mic and waits until every required mic has delivered its frame. It then either forwards one selected mic or mixes all enabled mics, and issues one codec `write` per frame. It sits between the `i2s_receive` instances (GPIO mic array) and the codec `writedata_left`/`writedata_right`/`write`/`write_ready` interface, all on the 50 MHz system clock.

## Interface
Parameters:
- `NUM_MICS`, 4: number of stereo I2S receivers (power of two, ≥2); `IW = clog2(NUM_MICS)`.
- `DATA_W`, 16: sample width, two's complement.

Ports:
- `clk_clk` in 1: system clock (CLOCK_50). Single clock domain.
- `reset_reset_n` in 1: synchronous, active-low reset.
- `sample_valid` in NUM_MICS: bit i pulses 1 cycle when receiver i has a new L/R pair (already in `clk_clk` domain).
- `sample_left` in NUM_MICS*DATA_W: mic i left at bits [i*DATA_W +: DATA_W].
- `sample_right` in NUM_MICS*DATA_W: same packing, right channel.
- `mode_mix` in 1: 1 = mix enabled mics, 0 = select one mic.
- `mic_sel` in IW: mic forwarded when `mode_mix`=0.
- `mic_en` in NUM_MICS: mics included in mix when `mode_mix`=1.
- `write_ready` in 1: codec can accept a sample pair this cycle.
- `write` out 1: codec write strobe.
- `writedata_left`, `writedata_right` out DATA_W: data to codec, held stable while `write` is pending.
- `busy` out 1: high in any state except IDLE.
- `frame_cnt` out 16: count of frames written, wraps 0xFFFF→0.
- `overrun_cnt` out 8: count of overwritten unconsumed samples, saturates at 255.

## Operation
- Per mic i: holding regs `hold_l[i]`, `hold_r[i]` and flag `pending[i]`. On `sample_valid[i]`: load hold regs, set pending.
- Required mask: `req` = `mic_en` if `mode_mix`=1, else one-hot(`mic_sel`). `req`, `mode_mix` and `mic_sel` are latched at IDLE→ACCUM and are constant for the rest of the frame.
- FSM:
  - IDLE: if `req != 0` and `(pending & req) == req`, then latch config, set idx=0, clear acc, go to ACCUM. `req == 0` never starts a frame.
  - ACCUM: one mic per cycle, idx = 0..NUM_MICS-1. If `req[idx]`: acc_l += sext(`hold_l[idx]`), acc_r likewise, clear `pending[idx]`. After idx = NUM_MICS-1, go to OUTPUT.
  - OUTPUT: register writedata. Mix mode: `acc >>> IW` (arithmetic shift, fixed divide by NUM_MICS regardless of enabled count, no saturation needed). Select mode: acc unchanged, equal to the selected sample. Go to WRITE.
  - WRITE: `write = write_ready` (combinational). On the cycle `write`=1: frame_cnt += 1, go to IDLE. Waits indefinitely for `write_ready`.
- Accumulators are DATA_W+IW bits signed.
- Overrun: `sample_valid[i]` while `pending[i]`=1 and mic i is not being consumed that cycle overwrites the hold regs, keeps pending=1, and increments overrun_cnt (saturating). Multiple simultaneous overruns in one cycle count as +1.
- Valid on the consuming cycle (ACCUM, idx=i): the accumulator uses the old hold value, the new value loads, pending stays 1. This is not an overrun.
- Samples arriving during OUTPUT/WRITE are buffered and used by the next frame.

## Timing
- Reset values: `write`=0, writedata=0, `busy`=0, `frame_cnt`=0, `overrun_cnt`=0, pending=0, acc=0, state IDLE.
- Reset applied mid-frame: frame is discarded, no `write`, all state returns to reset values on the next edge.
- Latency: last required `sample_valid` in cycle t → IDLE detect t+1 → ACCUM t+2..t+1+NUM_MICS → OUTPUT t+2+NUM_MICS → `write` in cycle t+3+NUM_MICS if `write_ready`=1. For NUM_MICS=4 this is t+7.
- `write` is never high outside WRITE and is high for exactly one cycle per frame.
- writedata is stable from OUTPUT until the cycle after `write`.
- Maximum throughput: one frame per NUM_MICS+3 cycles, far above 48 kHz.

## Test plan
- Select mode, `mic_sel`=2, mic 2 valid with L=0x1234 R=0xFEDC in cycle t, `write_ready`=1 → `write` in cycle t+7 with 0x1234/0xFEDC, `frame_cnt`=1, pending[2]=0.
- Mix, `mic_en`=4'b1111, L = 100, 200, -300, 400 → writedata_left = 400>>>2 = 100. All L = 0x8000 → 0x8000 (no wrap).
- Mix, `mic_en`=4'b0011, only mics 0,1 valid → frame runs; mics 2,3 pending unaffected. `mic_en`=0 → no `write` ever.
- Second `sample_valid[1]` before consumption → `overrun_cnt`=1, newest value used. 300 overruns → `overrun_cnt`=255.
- `write_ready` held low 50 cycles in WRITE → `write`=0, `busy`=1, data stable. Raise it → single `write` pulse, then IDLE.
- `reset_reset_n` low during ACCUM → no `write`, all outputs and counters zero on the next cycle, and a new frame works after release.
